// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit producing the MIPS HI/LO pair.
// Define MULTDIV_UNSIGNED_EN to let op[1] select multu/divu.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic             DIV_ZERO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_uns;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_uns = op[1];
`else
  assign w_uns = op[1] & 1'b0;
`endif

  // Operand signs and magnitudes; unsigned ops skip conversion.
  assign w_sa = ~w_uns & SrcA[WIDTH-1];
  assign w_sb = ~w_uns & SrcB[WIDTH-1];
  assign w_ma = w_sa ? -SrcA : SrcA;
  assign w_mb = w_sb ? -SrcB : SrcB;

  // Shift-add step: HI half gains multiplicand when multiplier LSB is 1.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_a} : '0);

  // Restoring divide step: remainder shifted with next dividend bit.
  assign w_shl  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_shl - {1'b0, r_b};

  assign w_r = r_acc[2*WIDTH-1:WIDTH];
  assign w_q = r_acc[WIDTH-1:0];

  // Control FSM, iterative datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      DIV_ZERO <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div <= op[0];
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_a   <= w_ma;
            r_b   <= w_mb;
            r_cnt <= '0;
            if (op[0] && (SrcB == '0)) begin
              DIV_ZERO <= 1'b1;
              done     <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_acc   <= {{WIDTH{1'b0}}, op[0] ? w_ma : w_mb};
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_div) begin
            if (!w_diff[WIDTH])
              r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
              r_acc <= {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_div) begin
            LO <= (r_sa ^ r_sb) ? -w_q : w_q;
            HI <= r_sa ? -w_r : w_r;
          end else begin
            {HI, LO} <= (r_sa ^ r_sb) ? -r_acc : r_acc;
          end
          DIV_ZERO <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Expected HI/LO/flag/cycle queued at issue, checked on done.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic        DIV_ZERO;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .DIV_ZERO(DIV_ZERO), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("HI", 64'(HI), 64'(e.hi));
        chk("LO", 64'(LO), 64'(e.lo));
        chk("DIV_ZERO", 64'(DIV_ZERO), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic kick(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] hi,
                      input logic [31:0] lo, input logic dz,
                      input int lat, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    SrcA  = a;
    SrcB  = b;
    e.hi  = hi;
    e.lo  = lo;
    e.dz  = dz;
    e.cyc = cyc + lat;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
  endtask

  task automatic wait_done(input string nm, input int busy_exp);
    int nb;
    int n;
    nb = 0;
    n  = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      n++;
    end
    if (n >= 100) begin
      chk({nm, "_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(busy_exp));
  endtask

  task automatic run(input string nm, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo,
                     input logic dz, input int lat, input int bexp);
    kick(o, a, b, hi, lo, dz, lat, 1'b1);
    wait_done(nm, bexp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(DIV_ZERO), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);

    run("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33);
    run("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 33);
    run("div_zero", 2'b01, 32'd55, 32'd0,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1, 0);
`ifdef MULTDIV_UNSIGNED_EN
    run("mulu_ff_2", 2'b10, 32'hFFFF_FFFF, 32'd2,
        32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34, 33);
`else
    run("mul_op2_ff_2", 2'b10, 32'hFFFF_FFFF, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34, 33);
`endif
    run("div_100_7", 2'b01, 32'd100, 32'd7,
        32'd2, 32'd14, 1'b0, 34, 33);
    run("div_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE,
        32'd1, 32'hFFFF_FFFD, 1'b0, 34, 33);
    run("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 32'h8000_0000, 1'b0, 34, 33);
    run("mul_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 32'd0, 1'b0, 34, 33);

    // Second start mid-operation must be dropped.
    kick(2'b00, 32'd5, 32'd5, 32'd0, 32'h19, 1'b0, 34, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b01;
    SrcA  = 32'd1234;
    SrcB  = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("mul_5_5_ign", 23);
    repeat (40) @(negedge clk);

    // Reset mid-operation: no result, no done pulse.
    kick(2'b00, 32'h0001_0000, 32'h0001_0000,
         32'd0, 32'd0, 1'b0, 34, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_c15_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    chk("midrst_idle_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
